// File: rtl/adam_spi_pkg.sv
// Shared definitions for the SPI slave: controller states and synchronizer depth.
package adam_spi_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

endpackage

// File: rtl/adam_spi_slave_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall detection
// on the synchronized level.
module adam_spi_slave_sync
   import adam_spi_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic sync_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign sync_o = sync_q[SYNC_STAGES-1];
   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/adam_spi_slave.sv
// SPI slave with oversampled (clk_i >= 8x SCLK) pins, MSB-first framing and
// single-entry rx/tx holding registers with valid/ready handshakes.
//
//  state     | meaning
//  ST_IDLE   | not selected; MISO disabled, bit counter and rx shift held clear
//  ST_ACTIVE | selected; sampling MOSI and shifting MISO on synced SCLK edges
module adam_spi_slave
   import adam_spi_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter bit                    CPHA       = 1'b0,
   parameter bit                    CPOL       = 1'b0,
   parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_sclk_i,
   input  logic                  spi_ss_n_i,
   input  logic                  spi_mosi_i,
   output logic                  spi_miso_o,
   output logic                  spi_miso_oe_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic                  rx_overrun_o,
   output logic                  tx_underrun_o
);

   localparam int unsigned     CNT_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
   localparam logic [1:0]      SETTLE_DONE = 2'(SYNC_STAGES);

   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic ss_sync, ss_rise_unused, ss_fall;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   adam_spi_slave_sync #(.RESET_VAL(CPOL)) u_sync_sclk (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (spi_sclk_i),
      .sync_o  (sclk_lvl_unused),
      .rise_o  (sclk_rise),
      .fall_o  (sclk_fall)
   );

   adam_spi_slave_sync #(.RESET_VAL(1'b1)) u_sync_ss (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (spi_ss_n_i),
      .sync_o  (ss_sync),
      .rise_o  (ss_rise_unused),
      .fall_o  (ss_fall)
   );

   adam_spi_slave_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .async_i (spi_mosi_i),
      .sync_o  (mosi_sync),
      .rise_o  (mosi_rise_unused),
      .fall_o  (mosi_fall_unused)
   );

   logic lead_edge, trail_edge, sample_edge, shift_edge;

   assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
   assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
   assign sample_edge = CPHA ? trail_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : trail_edge;

   spi_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  rx_ovr_q, rx_ovr_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [DATA_WIDTH-1:0] tx_hold_q, tx_hold_d;
   logic                  tx_full_q, tx_full_d;
   logic                  tx_udr_q, tx_udr_d;
   logic                  armed_q, armed_d;
   logic [1:0]            settle_q, settle_d;
   logic                  load;
   logic [DATA_WIDTH-1:0] rx_word;

   assign rx_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_sync};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         tx_shift_q <= '0;
         tx_hold_q  <= '0;
         tx_full_q  <= 1'b0;
         tx_udr_q   <= 1'b0;
         armed_q    <= 1'b0;
         settle_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         tx_shift_q <= tx_shift_d;
         tx_hold_q  <= tx_hold_d;
         tx_full_q  <= tx_full_d;
         tx_udr_q   <= tx_udr_d;
         armed_q    <= armed_d;
         settle_q   <= settle_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_shift_d = rx_shift_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = 1'b0;
      tx_shift_d = tx_shift_q;
      tx_hold_d  = tx_hold_q;
      tx_full_d  = tx_full_q;
      tx_udr_d   = 1'b0;
      armed_d    = armed_q;
      settle_d   = settle_q;
      load       = 1'b0;

      // A select held low through reset must not look like a fresh falling
      // edge, so arming waits for real pin samples showing ss_n high.
      if (settle_q != SETTLE_DONE) begin
         settle_d = settle_q + 2'd1;
      end else if (ss_sync) begin
         armed_d = 1'b1;
      end

      if (rx_valid_q && rx_ready_i) begin
         rx_valid_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE: begin
            cnt_d      = '0;
            rx_shift_d = '0;
            if (ss_fall && armed_q) begin
               state_d = ST_ACTIVE;
               load    = !CPHA;
            end
         end
         ST_ACTIVE: begin
            if (ss_sync) begin
               state_d    = ST_IDLE;
               cnt_d      = '0;
               rx_shift_d = '0;
            end else if (sample_edge) begin
               rx_shift_d = rx_word;
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
                  if (rx_valid_q && !rx_ready_i) begin
                     rx_ovr_d = 1'b1;
                  end else begin
                     rx_data_d  = rx_word;
                     rx_valid_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (shift_edge) begin
               // Counter at zero on a shift edge marks a word boundary in both phases.
               if (cnt_q == '0) begin
                  load = 1'b1;
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (tx_valid_i && !tx_full_q) begin
         tx_hold_d = tx_data_i;
         tx_full_d = 1'b1;
      end

      if (load) begin
         if (tx_full_q) begin
            tx_shift_d = tx_hold_q;
            tx_full_d  = 1'b0;
         end else begin
            tx_shift_d = TX_IDLE;
            tx_udr_d   = 1'b1;
         end
      end
   end

   assign spi_miso_oe_o = (state_q == ST_ACTIVE);
   assign spi_miso_o    = (state_q == ST_ACTIVE) & tx_shift_q[DATA_WIDTH-1];
   assign tx_ready_o    = ~tx_full_q;
   assign rx_data_o     = rx_data_q;
   assign rx_valid_o    = rx_valid_q;
   assign rx_overrun_o  = rx_ovr_q;
   assign tx_underrun_o = tx_udr_q;

endmodule

// File: tb/tb_adam_spi_slave.sv
// Directed bench: a mode-0 and a mode-3 slave driven by a bit-banged master at clk/8.
module tb_adam_spi_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sclk0 = 1'b0, ss0_n = 1'b1;
   logic       sclk3 = 1'b1, ss3_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso0, oe0, miso3, oe3;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid0 = 1'b0, tx_valid3 = 1'b0;
   logic       tx_ready0, tx_ready3;
   logic [7:0] rx_data0, rx_data3;
   logic       rx_valid0, rx_valid3;
   logic       rx_ready = 1'b1;
   logic       ovr0, udr0, ovr3, udr3;

   int total = 0;
   int bad = 0;
   int n_ovr0 = 0, n_udr0 = 0, n_ovr3 = 0, n_udr3 = 0;
   logic [7:0] rxq0[$];
   logic [7:0] rxq3[$];

   always #5 clk = ~clk;

   adam_spi_slave #(.DATA_WIDTH(8), .CPHA(1'b0), .CPOL(1'b0), .TX_IDLE(8'hFF)) dut0 (
      .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk0), .spi_ss_n_i(ss0_n), .spi_mosi_i(mosi),
      .spi_miso_o(miso0), .spi_miso_oe_o(oe0), .tx_data_i(tx_data), .tx_valid_i(tx_valid0),
      .tx_ready_o(tx_ready0), .rx_data_o(rx_data0), .rx_valid_o(rx_valid0), .rx_ready_i(rx_ready),
      .rx_overrun_o(ovr0), .tx_underrun_o(udr0)
   );

   adam_spi_slave #(.DATA_WIDTH(8), .CPHA(1'b1), .CPOL(1'b1), .TX_IDLE(8'hFF)) dut3 (
      .clk_i(clk), .rst_i(rst), .spi_sclk_i(sclk3), .spi_ss_n_i(ss3_n), .spi_mosi_i(mosi),
      .spi_miso_o(miso3), .spi_miso_oe_o(oe3), .tx_data_i(tx_data), .tx_valid_i(tx_valid3),
      .tx_ready_o(tx_ready3), .rx_data_o(rx_data3), .rx_valid_o(rx_valid3), .rx_ready_i(rx_ready),
      .rx_overrun_o(ovr3), .tx_underrun_o(udr3)
   );

   always @(posedge clk) begin
      if (rx_valid0 && rx_ready) rxq0.push_back(rx_data0);
      if (rx_valid3 && rx_ready) rxq3.push_back(rx_data3);
      if (ovr0) n_ovr0++;
      if (udr0) n_udr0++;
      if (ovr3) n_ovr3++;
      if (udr3) n_udr3++;
   end

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   task automatic begin_frame(input bit m3);
      if (m3) ss3_n = 1'b0;
      else    ss0_n = 1'b0;
      half();
   endtask

   task automatic end_frame(input bit m3);
      if (m3) begin
         ss3_n = 1'b1;
         sclk3 = 1'b1;
      end else begin
         ss0_n = 1'b1;
         sclk0 = 1'b0;
      end
      half();
      half();
   endtask

   // Mode 0 with last=1 leaves SCLK high so end_frame returns it to idle together with ss_n.
   task automatic xfer(input bit m3, input logic [7:0] w, input int nbits, input bit last,
                       output logic [7:0] r);
      r = '0;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!m3) begin
            mosi = w[i];
            half();
            r[i] = miso0;
            sclk0 = 1'b1;
            half();
            if (!(last && i == 8 - nbits)) sclk0 = 1'b0;
         end else begin
            sclk3 = 1'b0;
            mosi = w[i];
            half();
            r[i] = miso3;
            sclk3 = 1'b1;
            half();
         end
      end
   endtask

   task automatic tx_push(input bit m3, input logic [7:0] d);
      int n = 0;
      while ((m3 ? tx_ready3 : tx_ready0) !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 200) begin
         bad++;
         $display("FAIL tx_push_wait: tx_ready never rose within %0d cycles (mode%0d)", n, m3 ? 3 : 0);
      end
      tx_data = d;
      if (m3) tx_valid3 = 1'b1;
      else    tx_valid0 = 1'b1;
      @(negedge clk);
      tx_valid0 = 1'b0;
      tx_valid3 = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (miso0 !== 1'b0)    begin bad++; $display("FAIL rst_miso0: got %b want 0", miso0); end
      total++; if (oe0 !== 1'b0)      begin bad++; $display("FAIL rst_oe0: got %b want 0", oe0); end
      total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rst_tx_ready0: got %b want 1", tx_ready0); end
      total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL rst_rx_valid0: got %b want 0", rx_valid0); end
      total++; if (rx_data0 !== 8'h00) begin bad++; $display("FAIL rst_rx_data0: got %h want 00", rx_data0); end
      total++; if (ovr0 !== 1'b0 || udr0 !== 1'b0) begin bad++; $display("FAIL rst_pulses0: got ovr=%b udr=%b want 0 0", ovr0, udr0); end
      total++; if (oe3 !== 1'b0 || miso3 !== 1'b0) begin bad++; $display("FAIL rst_mode3_pins: got oe=%b miso=%b want 0 0", oe3, miso3); end
      total++; if (tx_ready3 !== 1'b1) begin bad++; $display("FAIL rst_tx_ready3: got %b want 1", tx_ready3); end
      rst = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_mode0_basic();
      logic [7:0] r;
      int q0 = rxq0.size();
      int u0 = n_udr0;
      int o0 = n_ovr0;
      tx_push(0, 8'h3C);
      begin_frame(0);
      total++; if (oe0 !== 1'b1) begin bad++; $display("FAIL m0_oe_active: got %b want 1", oe0); end
      xfer(0, 8'hA5, 8, 1'b1, r);
      end_frame(0);
      repeat (4) @(negedge clk);
      total++; if (r !== 8'h3C) begin bad++; $display("FAIL m0_master_read: got %h want 3c", r); end
      total++; if (rxq0.size() - q0 !== 1) begin bad++; $display("FAIL m0_rx_count: got %0d want 1", rxq0.size() - q0); end
      else begin
         total++; if (rxq0[q0] !== 8'hA5) begin bad++; $display("FAIL m0_rx_word: got %h want a5", rxq0[q0]); end
      end
      total++; if (n_udr0 - u0 !== 0 || n_ovr0 - o0 !== 0) begin bad++; $display("FAIL m0_no_pulses: got udr=%0d ovr=%0d want 0 0", n_udr0 - u0, n_ovr0 - o0); end
      total++; if (oe0 !== 1'b0 || miso0 !== 1'b0) begin bad++; $display("FAIL m0_idle_pins: got oe=%b miso=%b want 0 0", oe0, miso0); end
      total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL m0_tx_ready_after: got %b want 1", tx_ready0); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r1, r2;
      int q3 = rxq3.size();
      int u3 = n_udr3;
      int o3 = n_ovr3;
      tx_push(1, 8'h56);
      fork
         begin
            begin_frame(1);
            xfer(1, 8'h12, 8, 1'b0, r1);
            xfer(1, 8'h34, 8, 1'b1, r2);
            end_frame(1);
         end
         tx_push(1, 8'h78);
      join
      repeat (4) @(negedge clk);
      total++; if (r1 !== 8'h56) begin bad++; $display("FAIL m3_master_read1: got %h want 56", r1); end
      total++; if (r2 !== 8'h78) begin bad++; $display("FAIL m3_master_read2: got %h want 78", r2); end
      total++; if (rxq3.size() - q3 !== 2) begin bad++; $display("FAIL m3_rx_count: got %0d want 2", rxq3.size() - q3); end
      else begin
         total++; if (rxq3[q3] !== 8'h12)   begin bad++; $display("FAIL m3_rx_word1: got %h want 12", rxq3[q3]); end
         total++; if (rxq3[q3+1] !== 8'h34) begin bad++; $display("FAIL m3_rx_word2: got %h want 34", rxq3[q3+1]); end
      end
      total++; if (n_udr3 - u3 !== 0 || n_ovr3 - o3 !== 0) begin bad++; $display("FAIL m3_no_pulses: got udr=%0d ovr=%0d want 0 0", n_udr3 - u3, n_ovr3 - o3); end
   endtask

   task automatic test_underrun();
      logic [7:0] r;
      int u0 = n_udr0;
      begin_frame(0);
      xfer(0, 8'h00, 8, 1'b1, r);
      end_frame(0);
      total++; if (r !== 8'hFF) begin bad++; $display("FAIL udr_master_read: got %h want ff", r); end
      total++; if (n_udr0 - u0 !== 1) begin bad++; $display("FAIL udr_pulse_count: got %0d want 1", n_udr0 - u0); end
   endtask

   task automatic test_overrun();
      logic [7:0] r;
      int q0 = rxq0.size();
      int o0 = n_ovr0;
      rx_ready = 1'b0;
      begin_frame(0);
      xfer(0, 8'h11, 8, 1'b0, r);
      total++; if (n_ovr0 - o0 !== 0) begin bad++; $display("FAIL ovr_early: got %0d pulses after word1 want 0", n_ovr0 - o0); end
      xfer(0, 8'h22, 8, 1'b1, r);
      end_frame(0);
      total++; if (rx_valid0 !== 1'b1) begin bad++; $display("FAIL ovr_valid_held: got %b want 1", rx_valid0); end
      total++; if (rx_data0 !== 8'h11) begin bad++; $display("FAIL ovr_data_kept: got %h want 11", rx_data0); end
      total++; if (n_ovr0 - o0 !== 1) begin bad++; $display("FAIL ovr_pulse_count: got %0d want 1", n_ovr0 - o0); end
      rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (rxq0.size() - q0 !== 1) begin bad++; $display("FAIL ovr_drain_count: got %0d want 1", rxq0.size() - q0); end
      else begin
         total++; if (rxq0[q0] !== 8'h11) begin bad++; $display("FAIL ovr_drain_word: got %h want 11", rxq0[q0]); end
      end
      total++; if (rx_valid0 !== 1'b0) begin bad++; $display("FAIL ovr_valid_clear: got %b want 0", rx_valid0); end
   endtask

   task automatic test_abort();
      logic [7:0] r;
      int q0 = rxq0.size();
      int o0 = n_ovr0;
      begin_frame(0);
      xfer(0, 8'hF0, 5, 1'b1, r);
      end_frame(0);
      begin_frame(0);
      xfer(0, 8'hC3, 8, 1'b1, r);
      end_frame(0);
      repeat (4) @(negedge clk);
      total++; if (rxq0.size() - q0 !== 1) begin bad++; $display("FAIL abort_rx_count: got %0d want 1", rxq0.size() - q0); end
      else begin
         total++; if (rxq0[q0] !== 8'hC3) begin bad++; $display("FAIL abort_rx_word: got %h want c3", rxq0[q0]); end
      end
      total++; if (n_ovr0 - o0 !== 0) begin bad++; $display("FAIL abort_no_overrun: got %0d want 0", n_ovr0 - o0); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      int q0;
      tx_push(0, 8'h99);
      begin_frame(0);
      xfer(0, 8'h5A, 3, 1'b1, r);
      rst = 1'b1;
      @(negedge clk);
      total++; if (oe0 !== 1'b0 || miso0 !== 1'b0) begin bad++; $display("FAIL rstmid_pins: got oe=%b miso=%b want 0 0", oe0, miso0); end
      total++; if (tx_ready0 !== 1'b1) begin bad++; $display("FAIL rstmid_tx_ready: got %b want 1", tx_ready0); end
      total++; if (rx_valid0 !== 1'b0 || rx_data0 !== 8'h00) begin bad++; $display("FAIL rstmid_rx: got valid=%b data=%h want 0 00", rx_valid0, rx_data0); end
      total++; if (ovr0 !== 1'b0 || udr0 !== 1'b0) begin bad++; $display("FAIL rstmid_pulses: got ovr=%b udr=%b want 0 0", ovr0, udr0); end
      rst = 1'b0;
      sclk0 = 1'b0;
      repeat (12) @(negedge clk);
      total++; if (oe0 !== 1'b0) begin bad++; $display("FAIL rstmid_no_rearm: got oe=%b want 0 with ss_n still low", oe0); end
      end_frame(0);
      q0 = rxq0.size();
      begin_frame(0);
      xfer(0, 8'h5A, 8, 1'b1, r);
      end_frame(0);
      repeat (4) @(negedge clk);
      total++; if (rxq0.size() - q0 !== 1) begin bad++; $display("FAIL rstmid_rx_count: got %0d want 1", rxq0.size() - q0); end
      else begin
         total++; if (rxq0[q0] !== 8'h5A) begin bad++; $display("FAIL rstmid_rx_word: got %h want 5a", rxq0[q0]); end
      end
   endtask

   initial begin
      test_reset();
      test_mode0_basic();
      test_back_to_back();
      test_underrun();
      test_overrun();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adam_spi_slave.md
ADAM_SPI_SLAVE -- requirements
Module: adam_spi_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bits per SPI word.
REQ-002 Parameter CPHA, default 0, SPI clock phase (0: sample leading edge; 1: sample trailing edge).
REQ-003 Parameter CPOL, default 0, SCLK idle level.
REQ-004 Parameter TX_IDLE, default all-ones, word shifted out on TX underrun.
REQ-005 clk_i  in  1  single system clock; all logic on rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 spi_sclk_i  in  1  SPI clock from master, asynchronous to clk_i.
REQ-008 spi_ss_n_i  in  1  slave select, active-low, asynchronous.
REQ-009 spi_mosi_i  in  1  master-out data, asynchronous.
REQ-010 spi_miso_o  out  1  slave-out data.
REQ-011 spi_miso_oe_o  out  1  MISO output enable, high while selected.
REQ-012 tx_data_i  in  DATA_WIDTH  next word to transmit; tx_valid_i in 1; tx_ready_o out 1.
REQ-013 rx_data_o  out  DATA_WIDTH  received word; rx_valid_o out 1; rx_ready_i in 1.
REQ-014 rx_overrun_o  out  1  one-cycle pulse, received word dropped.
REQ-015 tx_underrun_o  out  1  one-cycle pulse, TX_IDLE sent.

Function
REQ-016 sclk, ss_n, mosi SHALL pass a 2-flop synchronizer; edges detected on synced sclk; supported SCLK <= clk_i/8.
REQ-017 States IDLE, ACTIVE; IDLE->ACTIVE on synced ss_n falling; any state->IDLE on synced ss_n high.
REQ-018 Sample edge = leading edge (CPHA=0) or trailing edge (CPHA=1), relative to CPOL idle level; shift edge is the other.
REQ-019 Frames MSB-first; on each sample edge mosi shifts into rx shift register and bit counter increments, wrapping DATA_WIDTH-1 -> 0.
REQ-020 On the sample edge completing bit DATA_WIDTH-1, word is transferred to rx holding register; rx_valid_o rises the following cycle.
REQ-021 rx handshake: word consumed when rx_valid_o && rx_ready_i; rx_data_o stable while rx_valid_o high.
REQ-022 Word completes while rx_valid_o high and rx_ready_i low: new word dropped, old kept, rx_overrun_o pulses 1 cycle; completion coinciding with consumption is not an overrun.
REQ-023 tx holding register: tx_ready_o = holding empty; accepts on tx_valid_i && tx_ready_o.
REQ-024 Load point: CPHA=0 at IDLE->ACTIVE and at shift edge following each word's last sample; CPHA=1 at first shift edge of each word.
REQ-025 At load point, full holding register loads tx shift register and empties (same-cycle accept allowed next cycle); empty holding loads TX_IDLE and pulses tx_underrun_o.
REQ-026 spi_miso_o = tx shift register MSB while ACTIVE, 0 in IDLE; shift register shifts left on every non-load shift edge.
REQ-027 ss_n deasserted mid-word: partial rx bits discarded, counter cleared, no rx push, no overrun; tx holding register contents retained.
REQ-028 spi_miso_oe_o = 1 exactly while ACTIVE.

Reset
REQ-029 On rst_i: IDLE, counter 0, shift registers 0, holding registers empty, synchronizers to idle levels (ss_n=1, sclk=CPOL).
REQ-030 Reset outputs: spi_miso_o 0, spi_miso_oe_o 0, tx_ready_o 1 (from first cycle after reset), rx_valid_o 0, rx_data_o 0, both pulses 0.
REQ-031 Reset mid-transfer aborts; block re-arms only on a fresh ss_n falling edge.

Structure
REQ-032 State enum and synchronizer depth constant SHALL live in shared package adam_spi_pkg.
REQ-033 Synchronizer plus edge detector SHALL be one sub-module, adam_spi_slave_sync, instantiated per input.

Verification
REQ-034 Mode 0, clk/8, master sends 0xA5, tx preloaded 0x3C -> rx_data_o 0xA5 once, master reads 0x3C, no pulses.
REQ-035 Mode 3 (CPOL=1,CPHA=1), two back-to-back words 0x12,0x34 with tx 0x56,0x78 -> rx 0x12 then 0x34, master reads 0x56,0x78.
REQ-036 No tx loaded, master sends 0x00 -> master reads 0xFF, tx_underrun_o one pulse.
REQ-037 rx_ready_i held 0, words 0x11,0x22 -> rx_data_o stays 0x11, rx_overrun_o one pulse at second completion.
REQ-038 ss_n raised after 5 bits, then full word 0xC3 -> only 0xC3 delivered, bit alignment correct.
REQ-039 rst_i asserted after 3 bits -> all outputs at reset values next cycle; subsequent frame 0x5A received correctly.
